hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline stall and flush controller for the 5-stage RISC-V core. It complements the forwarding unit by handling the hazards forwarding cannot resolve: load-use dependencies, taken branches/jumps, and multi-cycle MDU ops (mul/div) that occupy EX for several cycles.
- Drives the stall and flush enables of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Keeps saturating performance counters for stall cycles and flush events.

Parameters:
- MDU_LATENCY, 4, total cycles an MDU op occupies EX (>=1).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- rs1_D  in  5  rs1 of the instruction in decode.
- rs2_D  in  5  rs2 of the instruction in decode.
- RD_E  in  5  destination of the instruction in execute.
- MemReadE  in  1  instruction in EX is a load.
- PCSrcE  in  1  branch/jump taken, resolved in EX.
- mdu_start_E  in  1  instruction in EX is an MDU op.
- perf_clr  in  1  synchronous clear of both counters.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- StallE  out  1  hold ID/EX.
- FlushD  out  1  clear IF/ID.
- FlushE  out  1  clear ID/EX.
- FlushM  out  1  clear EX/MEM (insert bubble).
- mdu_busy  out  1  FSM in BUSY.
- mdu_done  out  1  one-cycle pulse: last EX cycle of the MDU op.
- stall_cycles  out  CNT_W  count of cycles with StallD=1.
- flush_events  out  CNT_W  count of cycles with FlushD=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; counter cnt=0; both perf counters = 0.
  - All outputs are forced to 0 while rst=0, including combinational ones.
  - Reset during BUSY abandons the op with no mdu_done pulse.
- FSM states: IDLE and BUSY. The internal down-counter cnt has width $clog2(MDU_LATENCY)+1.
- Load-use detection (combinational, IDLE only):
  - lw_hz = MemReadE & (RD_E!=0) & (RD_E==rs1_D | RD_E==rs2_D).
- Branch flush (IDLE only):
  - If PCSrcE=1: FlushD=1 and FlushE=1.
  - PCSrcE has priority: lw_hz and mdu_start_E are ignored in that cycle. No stall is raised and the FSM does not enter BUSY.
- Load-use stall (IDLE, lw_hz=1, PCSrcE=0):
  - StallF=1, StallD=1, FlushE=1 for exactly one cycle.
  - The next cycle sees the load in MEM, so lw_hz clears naturally.
- MDU start (IDLE, mdu_start_E=1, PCSrcE=0):
  - MDU_LATENCY=1: no effect (no stall, no BUSY); mdu_done=1 that cycle.
  - Otherwise: StallF, StallD, StallE and FlushM are all 1 this cycle; next state is BUSY with cnt=MDU_LATENCY-2.
- BUSY:
  - cnt!=0: StallF, StallD, StallE, FlushM = 1; cnt decrements.
  - cnt==0: all stalls 0, mdu_done=1, next state IDLE.
  - Net effect: the op stays in EX for MDU_LATENCY cycles with MDU_LATENCY-1 stall cycles.
  - In BUSY, mdu_start_E, PCSrcE and lw_hz are ignored: EX holds the MDU op, so a taken PCSrcE is illegal and is checked by an assertion.
- Precedence when simultaneous: rst, then BUSY, then PCSrcE, then mdu_start_E, then lw_hz. mdu_start_E together with lw_hz resolves as an MDU start; its stall covers the decode dependency.
- mdu_busy = (state==BUSY).
- Performance counters:
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones.
  - perf_clr has priority over increment: the counter reads 0 on the next cycle.
- Outputs are combinational from the registered state and the inputs. There are no extra pipeline registers, so stalls take effect in the same cycle the hazard is detected.

Test Plan:
- Reset: hold rst=0 with PCSrcE=1 and mdu_start_E=1 -> all outputs 0, counters 0; release -> FlushD=FlushE=1 in the first active cycle.
- Load-use: MemReadE=1, RD_E=5, rs2_D=5 -> StallF=StallD=FlushE=1 for one cycle; stall_cycles=1. Repeat with RD_E=0 -> no stall.
- Taken branch together with load-use: PCSrcE=1 plus lw_hz -> FlushD=FlushE=1, StallF=0; flush_events increments to 1, stall_cycles unchanged.
- MDU, MDU_LATENCY=4: one-cycle mdu_start_E pulse ->
  - stalls asserted for 3 cycles (cycles 0 to 2);
  - mdu_busy=1 in cycles 1 to 3;
  - mdu_done=1 in cycle 3 only;
  - stall_cycles=3.
  - Also assert PCSrcE=1 during BUSY -> ignored and the assertion fires.
- Reset mid-op: drop rst in the second BUSY cycle -> immediate IDLE, all stalls 0, no mdu_done pulse.
- Counter saturation and clear: CNT_W=4, hold lw_hz for 20 cycles -> stall_cycles holds at 15. Assert perf_clr -> 0 next cycle even with lw_hz still 1.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage core. It resolves the hazards the
// forwarding unit cannot: load-use dependencies, taken branches/jumps, and
// multi-cycle MDU ops holding EX. It also counts stall cycles and flush events.
//
// There is no valid/ready handshake on this block. mdu_start_E is sampled as
// a level whenever the FSM is IDLE, and it is ignored while BUSY. mdu_done is
// a single-cycle pulse on the last EX cycle of the op.
module hazard_stall_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       RD_E,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic             mdu_start_E,
    input  logic             perf_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             state_dbg
);

    localparam int CW     = $clog2(MDU_LATENCY) + 1;
    // The start cycle and the final (done) cycle are not counted by cnt,
    // so the remaining BUSY stall cycles number MDU_LATENCY-2.
    localparam int LOAD_I = (MDU_LATENCY >= 2) ? MDU_LATENCY - 2 : 0;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_I);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          lw_hz;
    logic          stall_f, stall_d, stall_e;
    logic          flush_d, flush_e, flush_m;
    logic          done;

    assign lw_hz = MemReadE & (RD_E != 5'd0) & ((RD_E == rs1_D) | (RD_E == rs2_D));

    // State and MDU down-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state and raw hazard controls. Precedence is BUSY, then a taken
    // branch, then MDU start, then load-use.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (PCSrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (mdu_start_E) begin
                    if (MDU_LATENCY == 1) begin
                        done = 1'b1;
                    end else begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                        state_n = BUSY;
                        cnt_n   = CNT_LOAD;
                    end
                end else if (lw_hz) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    cnt_n   = cnt - CW'(1);
                end else begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Every output is held low while reset is asserted, including the
    // combinational ones.
    assign StallF    = rst & stall_f;
    assign StallD    = rst & stall_d;
    assign StallE    = rst & stall_e;
    assign FlushD    = rst & flush_d;
    assign FlushE    = rst & flush_e;
    assign FlushM    = rst & flush_m;
    assign mdu_done  = rst & done;
    assign mdu_busy  = rst & (state == BUSY);
    assign state_dbg = rst & state;

    // Saturating performance counters; a clear wins over an increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (StallD && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
            if (FlushD && (flush_events != '1)) flush_events <= flush_events + CNT_W'(1);
        end
    end

    // The MDU op owns EX while BUSY, so a taken branch there is illegal.
    a_no_branch_in_busy: assert property (
        @(posedge clk) disable iff (!rst) (state == BUSY) |-> !PCSrcE
    );

endmodule
